// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronizes and de-glitches the PS/2 lines, frames
// 11-bit serial words, and folds E0/F0 prefixes into toggle-marked key events.
module ps2_key_decoder #(
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [10:0] ps2_key,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        frame_error
);

  localparam int FILT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W   = $clog2(TIMEOUT + 1);
  localparam logic [FILT_W-1:0] FILT_LAST = FILT_W'(FILTER_LEN - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } frame_state_e;

  logic [1:0]        clk_sync_q;
  logic [1:0]        data_sync_q;
  logic              filt_q, filt_d;
  logic [FILT_W-1:0] filt_cnt_q, filt_cnt_d;
  logic              fall_strobe;
  logic              data_bit;

  frame_state_e      state_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic              parity_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [7:0]        rx_data_q;
  logic              rx_valid_q;
  logic              frame_error_q;

  logic              ext_q;
  logic              brk_q;
  logic [10:0]       key_q;

  // Both lines idle high, so the synchronizer comes out of reset at 1 and no
  // phantom falling edge is seen on release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      // NOTE: non-blocking assignments let every flop sample the pre-edge value,
      // which is what makes this a two-stage shift register rather than a wire.
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  always_comb begin
    // NOTE: defaults first, so every path assigns both outputs and no latch is inferred.
    filt_d     = filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != filt_q) begin
      if (filt_cnt_q == FILT_LAST) begin
        filt_d = clk_sync_q[1];
      end else begin
        filt_cnt_d = filt_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
    end else begin
      filt_q     <= filt_d;
      filt_cnt_q <= filt_cnt_d;
    end
  end

  // The strobe fires in the cycle the filter commits to low; data is sampled there.
  assign fall_strobe = filt_q & ~filt_d;
  assign data_bit    = data_sync_q[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      parity_q      <= 1'b0;
      to_cnt_q      <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      if (state_q == S_IDLE) begin
        to_cnt_q <= '0;
        if (fall_strobe && !data_bit) begin
          state_q   <= S_DATA;
          bit_cnt_q <= '0;
        end
      end else if (fall_strobe) begin
        to_cnt_q <= '0;
        unique case (state_q)
          S_DATA: begin
            shift_q   <= {data_bit, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
          end
          S_PARITY: begin
            parity_q <= data_bit;
            state_q  <= S_STOP;
          end
          S_STOP: begin
            state_q <= S_IDLE;
            // Odd parity over data plus parity bit, and a high stop bit.
            if (data_bit && (^{shift_q, parity_q})) begin
              rx_data_q  <= shift_q;
              rx_valid_q <= 1'b1;
            end else begin
              frame_error_q <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end else if (to_cnt_q == TO_LAST) begin
        state_q       <= S_IDLE;
        frame_error_q <= 1'b1;
      end else begin
        to_cnt_q <= to_cnt_q + 1'b1;
      end
    end
  end

  // Key assembly runs one cycle behind the receiver, on the registered byte.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
      key_q <= '0;
    end else if (frame_error_q) begin
      ext_q <= 1'b0;
      brk_q <= 1'b0;
    end else if (rx_valid_q) begin
      unique case (rx_data_q)
        8'hE0: ext_q <= 1'b1;
        8'hF0: brk_q <= 1'b1;
        8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
        default: begin
          key_q <= {~key_q[10], ~brk_q, ext_q, rx_data_q};
          ext_q <= 1'b0;
          brk_q <= 1'b0;
        end
      endcase
    end
  end

  assign ps2_key     = key_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign frame_error = frame_error_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Bench for ps2_key_decoder: a byte-level model predicts received bytes, key
// events and frame errors; a negedge monitor checks the DUT against it.
module tb_ps2_key_decoder;

  localparam int FL   = 8;
  localparam int TO   = 400;
  localparam int HALF = 20;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [10:0] ps2_key;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        frame_error;

  ps2_key_decoder #(.FILTER_LEN(FL), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ps2_key    (ps2_key),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  logic [7:0]  exp_rx[$];
  logic [10:0] exp_key[$];
  int          exp_err = 0;
  int          err_seen = 0;
  int          rx_count = 0;
  int          key_count = 0;
  logic        ext_m = 1'b0;
  logic        brk_m = 1'b0;
  logic [10:0] key_m = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Byte-level model of what a good frame must produce.
  task automatic model_good(input logic [7:0] b);
    exp_rx.push_back(b);
    if (b == 8'hE0) ext_m = 1'b1;
    else if (b == 8'hF0) brk_m = 1'b1;
    else if (b inside {8'hE1, 8'hFA, 8'hAA, 8'hEE, 8'hFE, 8'h00, 8'hFF}) begin
      ext_m = 1'b0;
      brk_m = 1'b0;
    end else begin
      key_m = {~key_m[10], ~brk_m, ext_m, b};
      exp_key.push_back(key_m);
      ext_m = 1'b0;
      brk_m = 1'b0;
    end
  endtask

  task automatic model_error();
    exp_err++;
    ext_m = 1'b0;
    brk_m = 1'b0;
  endtask

  // One PS/2 bit: data set while the clock is high, then a low phase.
  task automatic drive_bit(input logic b, input int glitch);
    ps2_data = b;
    wait_cyc(HALF);
    if (glitch > 0) begin
      ps2_clk = 1'b0;
      wait_cyc(glitch);
      ps2_clk = 1'b1;
      wait_cyc(HALF);
    end
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic bad_par, input logic bad_stop,
                            input int glitch_bit, input int glitch_len);
    logic [10:0] fr;
    fr = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    if (bad_par || bad_stop) model_error();
    else model_good(b);
    for (int i = 0; i < 11; i++) drive_bit(fr[i], (i == glitch_bit) ? glitch_len : 0);
    ps2_data = 1'b1;
    wait_cyc(HALF);
    check("frame_error_count", 32'(err_seen), 32'(exp_err));
  endtask

  task automatic send_partial(input int nbits);
    drive_bit(1'b0, 0);
    for (int i = 0; i < nbits; i++) drive_bit(1'($urandom_range(1, 0)), 0);
  endtask

  task automatic send_timeout(input int nbits);
    send_partial(nbits);
    ps2_data = 1'b1;
    model_error();
    wait_cyc(TO + 3 * HALF);
    check("timeout_error_count", 32'(err_seen), 32'(exp_err));
  endtask

  // Monitor: every rx pulse, error pulse and key change is matched to the model.
  initial begin
    logic        prev_rx = 1'b0;
    logic        prev_err = 1'b0;
    logic [10:0] last_key = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_rx  = 1'b0;
        prev_err = 1'b0;
        last_key = ps2_key;
      end else begin
        if (rx_valid) begin
          rx_count++;
          check("rx_pulse_single", 32'(prev_rx), 32'd0);
          check("rx_pending", 32'(exp_rx.size() > 0), 32'd1);
          if (exp_rx.size() > 0) check("rx_data", 32'(rx_data), 32'(exp_rx.pop_front()));
        end
        if (frame_error) begin
          err_seen++;
          check("err_pulse_single", 32'(prev_err), 32'd0);
        end
        if (ps2_key !== last_key) begin
          key_count++;
          check("key_latency", 32'(prev_rx), 32'd1);
          check("key_pending", 32'(exp_key.size() > 0), 32'd1);
          if (exp_key.size() > 0) check("key_value", 32'(ps2_key), 32'(exp_key.pop_front()));
        end
        prev_rx  = rx_valid;
        prev_err = frame_error;
        last_key = ps2_key;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int k0;
    int e0;
    logic [7:0] specials [9];
    specials = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hE1, 8'hFA, 8'hAA, 8'h00, 8'hFF};

    wait_cyc(4);
    check("reset_key", 32'(ps2_key), 32'd0);
    check("reset_rx_data", 32'(rx_data), 32'd0);
    check("reset_rx_valid", 32'(rx_valid), 32'd0);
    check("reset_frame_error", 32'(frame_error), 32'd0);
    reset = 1'b0;
    wait_cyc(5);

    // Plain make code.
    n0 = rx_count;
    send_frame(8'h1C, 1'b0, 1'b0, -1, 0);
    check("make_1c_rx_count", 32'(rx_count - n0), 32'd1);
    check("make_1c_rx_data", 32'(rx_data), 32'h1C);
    check("make_1c_key", 32'(ps2_key), 32'h61C);

    // Extended break: only the final byte updates the key.
    k0 = key_count;
    send_frame(8'hE0, 1'b0, 1'b0, -1, 0);
    send_frame(8'hF0, 1'b0, 1'b0, -1, 0);
    check("prefix_no_update", 32'(key_count - k0), 32'd0);
    send_frame(8'h75, 1'b0, 1'b0, -1, 0);
    check("ext_break_count", 32'(key_count - k0), 32'd1);
    check("ext_break_key", 32'(ps2_key), 32'h175);

    // Parity error, then the same byte with good parity.
    e0 = err_seen;
    n0 = rx_count;
    send_frame(8'h29, 1'b1, 1'b0, -1, 0);
    check("parity_err_pulses", 32'(err_seen - e0), 32'd1);
    check("parity_err_no_rx", 32'(rx_count - n0), 32'd0);
    check("parity_err_key_held", 32'(ps2_key), 32'h175);
    send_frame(8'h29, 1'b0, 1'b0, -1, 0);
    check("after_parity_key", 32'(ps2_key), 32'h629);

    // Timeout after start plus three data bits.
    e0 = err_seen;
    send_timeout(3);
    check("timeout_pulses", 32'(err_seen - e0), 32'd1);
    send_frame(8'h1C, 1'b0, 1'b0, -1, 0);
    check("after_timeout_key", 32'(ps2_key), 32'h21C);

    // Sub-threshold clock glitch mid-frame.
    send_frame(8'h5A, 1'b0, 1'b0, 5, FL - 1);
    check("glitch_key", 32'(ps2_key), 32'h65A);

    // Reset in the middle of a frame.
    n0 = rx_count;
    e0 = err_seen;
    send_partial(4);
    reset = 1'b1;
    wait_cyc(3);
    check("midreset_key", 32'(ps2_key), 32'd0);
    ps2_data = 1'b1;
    key_m = '0;
    ext_m = 1'b0;
    brk_m = 1'b0;
    reset = 1'b0;
    wait_cyc(TO + 20);
    check("midreset_no_rx", 32'(rx_count - n0), 32'd0);
    check("midreset_no_err", 32'(err_seen - e0), 32'd0);
    send_frame(8'h1C, 1'b0, 1'b0, -1, 0);
    check("after_reset_key", 32'(ps2_key), 32'h61C);

    // Randomized traffic.
    for (int it = 0; it < 60; it++) begin
      int kind;
      logic [7:0] b;
      int gb;
      int gl;
      kind = $urandom_range(99, 0);
      b = ($urandom_range(3, 0) == 0) ? specials[$urandom_range(8, 0)] : 8'($urandom);
      gb = ($urandom_range(2, 0) == 0) ? $urandom_range(10, 0) : -1;
      gl = $urandom_range(FL - 1, 1);
      if (kind < 70) send_frame(b, 1'b0, 1'b0, gb, gl);
      else if (kind < 80) send_frame(b, 1'b1, 1'b0, gb, gl);
      else if (kind < 90) send_frame(b, 1'b0, 1'b1, gb, gl);
      else send_timeout($urandom_range(9, 0));
      wait_cyc($urandom_range(10, 0));
    end

    wait_cyc(10);
    check("rx_queue_drained", 32'(exp_rx.size()), 32'd0);
    check("key_queue_drained", 32'(exp_key.size()), 32'd0);
    check("final_key", 32'(ps2_key), 32'(key_m));
    check("final_error_count", 32'(err_seen), 32'(exp_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_decoder.md
PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 Parameter FILTER_LEN, default 8: clk cycles the synchronized ps2_clk must hold a new level before the filtered clock changes.
REQ-002 Parameter TIMEOUT, default 50000: clk cycles without a filtered ps2_clk falling edge before an open frame is aborted.
REQ-003 clk  input  1  system clock; all logic on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock line, asynchronous, idle high.
REQ-006 ps2_data  input  1  raw PS/2 data line, asynchronous, idle high.
REQ-007 ps2_key  output  11  key event: [7:0] scancode, [8] extended, [9] pressed (1 = make, 0 = break), [10] toggles once per event.
REQ-008 rx_data  output  8  last byte received with correct framing, including prefix bytes.
REQ-009 rx_valid  output  1  one-cycle pulse when rx_data updates.
REQ-010 frame_error  output  1  one-cycle pulse on a parity error, stop-bit error or timeout.

Function
REQ-011 ps2_clk and ps2_data each pass through a 2-flop synchronizer before any use.
REQ-012 The filtered clock changes only after the synchronized ps2_clk holds the opposite level for FILTER_LEN consecutive cycles; shorter glitches are ignored.
REQ-013 Data is sampled only in the cycle a filtered falling edge is detected (fall strobe).
REQ-014 Frame FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: a fall strobe with data=0 enters DATA and sets bit count to 0; a fall strobe with data=1 is ignored.
REQ-016 DATA: each fall strobe shifts in one bit, LSB first; after the 8th bit the FSM enters PARITY.
REQ-017 PARITY: the fall strobe captures the parity bit and the FSM enters STOP.
REQ-018 STOP: the fall strobe ends the frame and the FSM returns to IDLE.
  - Frame is good when the 8 data bits plus parity contain an odd number of ones and stop = 1.
  - Otherwise frame_error pulses and the byte is discarded.
REQ-019 Timeout counter: cleared on every fall strobe and in IDLE.
  - Reaching TIMEOUT-1 outside IDLE forces IDLE, pulses frame_error and discards the partial byte.
REQ-020 Good frame: rx_data and rx_valid are registered at the clock edge following the stop-bit fall strobe (latency 1).
REQ-021 Prefix decode uses the good byte in the same cycle rx_valid is asserted:
  - E0 sets the ext flag.
  - F0 sets the brk flag.
  - Neither prefix produces a ps2_key update.
REQ-022 Bytes E1, FA, AA, EE, FE, 00 and FF produce no ps2_key update and clear both flags.
REQ-023 Any other good byte:
  - Updates ps2_key on the clock edge after rx_valid (latency 2 from the stop strobe).
  - ps2_key becomes {~ps2_key[10], ~brk, ext, byte}.
  - Both flags clear in the same cycle.
REQ-024 A frame_error clears both ext and brk and leaves ps2_key unchanged.
REQ-025 ps2_key holds its value between events; only bit 10 marks a new event, so identical repeated events remain distinguishable.
REQ-026 Prefixes accumulate in any order (E0 F0 xx and F0 E0 xx both give ext=1, pressed=0).

Reset
REQ-027 While reset is high, asynchronously:
  - ps2_key = 0, rx_data = 0, rx_valid = 0, frame_error = 0.
  - FSM = IDLE, flags cleared, counters cleared.
  - Synchronizer and filter flops = 1.
REQ-028 Reset asserted mid-frame aborts the frame with no output or error pulse; the first frame after release decodes normally.

Verification
REQ-029 Make frame 0x1C (parity 0, stop 1) -> rx_valid once with rx_data = 1C; one cycle later ps2_key = {1, 1, 0, 1C}.
REQ-030 Sequence E0 F0 75 -> exactly one ps2_key update: [8] = 1, [9] = 0, [7:0] = 75, [10] inverted from its prior value; no update for E0 or F0.
REQ-031 Frame 0x29 with a wrong parity bit -> frame_error pulses once, no rx_valid, ps2_key unchanged; the following frame 0x29 with correct parity decodes with ext = 0.
REQ-032 Start plus 3 data bits, then ps2_clk held high TIMEOUT cycles -> frame_error pulses once, FSM in IDLE; the next full frame decodes correctly.
REQ-033 Glitch of FILTER_LEN-1 cycles low on ps2_clk in the middle of a frame -> no extra bit is sampled and the byte decodes correctly.
REQ-034 Reset asserted after bit 4 of a frame, then released, then a full frame 0x1C -> no output during or after the aborted frame; the new frame gives ps2_key = {1, 1, 0, 1C}.
